// File: rtl/clock_div_pkg.sv
// rtl/clock_div_pkg.sv - shared constants and divisor helper for clock_div_bank
package clock_div_pkg;

  localparam int unsigned CW_DEFAULT      = 30;
  localparam int unsigned RST_DIV_DEFAULT = 50000000;

  // Divisor arithmetic is done at this width; channel widths up to 32 bits fit.
  localparam int unsigned           DIV_CALC_W = 32;
  localparam logic [DIV_CALC_W-1:0] DIV_MIN    = 32'd2;

  function automatic logic [DIV_CALC_W-1:0] eff_div(input logic [DIV_CALC_W-1:0] div);
    return (div < DIV_MIN) ? DIV_MIN : div;
  endfunction

endpackage

// File: rtl/clock_div_channel.sv
// rtl/clock_div_channel.sv - one divider channel: counter, shadow/active divisor, tick and square wave
module clock_div_channel
  import clock_div_pkg::*;
#(
  parameter int unsigned CW      = CW_DEFAULT,
  parameter int unsigned RST_DIV = RST_DIV_DEFAULT
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          en_i,
  input  logic          clr_i,
  input  logic          wr_i,
  input  logic [CW-1:0] div_i,
  output logic          tick_o,
  output logic          sq_o
);

  localparam logic [CW-1:0] RST_VAL = CW'(RST_DIV);

  logic [CW-1:0] active_q, active_d;
  logic [CW-1:0] shadow_q, shadow_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick_q, tick_d;
  logic          sq_q, sq_d;

  logic [CW-1:0] div_eff;
  logic [CW-1:0] last_cnt;
  logic [CW-1:0] half;
  logic          run;
  logic          wrap;

  always_comb begin
    div_eff  = CW'(eff_div(DIV_CALC_W'(active_q)));
    last_cnt = div_eff - CW'(1);
    half     = div_eff >> 1;
    run      = en_i & ~clr_i;
    wrap     = run & (cnt_q == last_cnt);
  end

  // sq rises with the wrap and falls once the count reaches floor(D/2).
  always_comb begin
    shadow_d = wr_i ? div_i : shadow_q;
    active_d = active_q;
    cnt_d    = '0;
    tick_d   = 1'b0;
    sq_d     = 1'b0;
    if (!run) begin
      active_d = shadow_q;
    end else if (wrap) begin
      active_d = wr_i ? div_i : shadow_q;
      tick_d   = 1'b1;
      sq_d     = 1'b1;
    end else begin
      cnt_d = cnt_q + CW'(1);
      sq_d  = (cnt_d == half) ? 1'b0 : sq_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      active_q <= RST_VAL;
      shadow_q <= RST_VAL;
      cnt_q    <= '0;
      tick_q   <= 1'b0;
      sq_q     <= 1'b0;
    end else begin
      active_q <= active_d;
      shadow_q <= shadow_d;
      cnt_q    <= cnt_d;
      tick_q   <= tick_d;
      sq_q     <= sq_d;
    end
  end

  assign tick_o = tick_q;
  assign sq_o   = sq_q;

endmodule

// File: rtl/clock_div_bank.sv
// rtl/clock_div_bank.sv - multi-channel programmable clock-enable generator
module clock_div_bank
  import clock_div_pkg::*;
#(
  parameter int unsigned NCH     = 4,
  parameter int unsigned CW      = CW_DEFAULT,
  parameter int unsigned RST_DIV = RST_DIV_DEFAULT
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic [NCH-1:0]                       en_i,
  input  logic [NCH-1:0]                       clr_i,
  input  logic                                 cfg_we_i,
  input  logic [$clog2(NCH > 1 ? NCH : 2)-1:0] cfg_ch_i,
  input  logic [CW-1:0]                        cfg_div_i,
  output logic [NCH-1:0]                       tick_o,
  output logic [NCH-1:0]                       sq_o
);

  localparam int unsigned CHW = $clog2(NCH > 1 ? NCH : 2);

  logic [NCH-1:0] wr;

  // Out-of-range channel numbers match no decode line and are dropped.
  always_comb begin
    wr = '0;
    for (int i = 0; i < NCH; i++) begin
      wr[i] = cfg_we_i && (cfg_ch_i == CHW'(i));
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    clock_div_channel #(
      .CW     (CW),
      .RST_DIV(RST_DIV)
    ) u_ch (
      .clk_i (clk_i),
      .rst_ni(rst_ni),
      .en_i  (en_i[g]),
      .clr_i (clr_i[g]),
      .wr_i  (wr[g]),
      .div_i (cfg_div_i),
      .tick_o(tick_o[g]),
      .sq_o  (sq_o[g])
    );
  end

endmodule
